// File: rtl/spu32_irq_ctrl_wb8_if.sv
// spu32_irq_ctrl_wb8_if: 8-bit Wishbone slave port of the interrupt controller.
interface spu32_irq_ctrl_wb8_if;
   logic [2:0] ADR_I;
   logic [7:0] DAT_I;
   logic [7:0] DAT_O;
   logic       CYC_I;
   logic       STB_I;
   logic       WE_I;
   logic       ACK_O;
   logic       STALL_O;
   modport slave (input ADR_I, DAT_I, CYC_I, STB_I, WE_I, output DAT_O, ACK_O, STALL_O);
   modport master (output ADR_I, DAT_I, CYC_I, STB_I, WE_I, input DAT_O, ACK_O, STALL_O);
endinterface

// File: rtl/spu32_irq_ctrl_wb8.sv
// spu32_irq_ctrl_wb8: 8-source interrupt controller with edge/level modes and claim register.
// Define SPU32_IRQ_SYNC_EN to pass IRQ_I through 2-flop synchronizers.
module spu32_irq_ctrl_wb8 #(
   parameter int         NUM_SOURCES = 8,
   parameter logic [7:0] EDGE_RESET  = 8'h00
) (
   input  logic                   CLK_I,
   input  logic                   RST_I,
   spu32_irq_ctrl_wb8_if.slave    bus,
   input  logic [NUM_SOURCES-1:0] IRQ_I,
   output logic                   INTERRUPT_O
);
   localparam logic [7:0] MASK = 8'((9'd1 << NUM_SOURCES) - 9'd1);
   logic [7:0] irq, s, act, clr, rd;
   logic [7:0] pend_q, pend_d, en_q, en_d, mode_q, mode_d, prev_q, dat_q, dat_d;
   logic       ack_q, ack_d, int_q, int_d, req, wr, active;
   logic [2:0] idx;
   assign irq = 8'(IRQ_I) & MASK;
`ifdef SPU32_IRQ_SYNC_EN
   logic [7:0] sync1_q, sync2_q;
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         sync1_q <= 8'h00;
         sync2_q <= 8'h00;
      end else begin
         sync1_q <= irq;
         sync2_q <= sync1_q;
      end
   end
   assign s = sync2_q;
`else
   assign s = irq;
`endif
   always_comb begin
      req = bus.CYC_I & bus.STB_I & ~ack_q;
      wr = req & bus.WE_I;
      act = pend_q & en_q;
      active = |act;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) if (act[i]) idx = 3'(i);
      // W1C and claim clears only matter for edge-mode bits; a new rising edge overrides them
      clr = (wr && bus.ADR_I == 3'd0 ? bus.DAT_I : 8'h00)
          | (req && !bus.WE_I && bus.ADR_I == 3'd4 && active ? 8'h01 << idx : 8'h00);
      pend_d = MASK & ((mode_q & ((pend_q & ~clr) | (s & ~prev_q))) | (~mode_q & s));
      en_d = wr && bus.ADR_I == 3'd1 ? bus.DAT_I & MASK : en_q;
      mode_d = wr && bus.ADR_I == 3'd2 ? bus.DAT_I & MASK : mode_q;
      rd = bus.ADR_I == 3'd0 ? pend_q :
           bus.ADR_I == 3'd1 ? en_q :
           bus.ADR_I == 3'd2 ? mode_q :
           bus.ADR_I == 3'd3 ? act :
           bus.ADR_I == 3'd4 ? (active ? {1'b1, 4'b0000, idx} : 8'h00) : 8'h00;
      dat_d = req && !bus.WE_I ? rd : 8'h00;
      ack_d = req;
      int_d = active;
   end
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         pend_q <= 8'h00;
         en_q   <= 8'h00;
         mode_q <= EDGE_RESET & MASK;
         prev_q <= 8'h00;
         dat_q  <= 8'h00;
         ack_q  <= 1'b0;
         int_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         en_q   <= en_d;
         mode_q <= mode_d;
         prev_q <= s;
         dat_q  <= dat_d;
         ack_q  <= ack_d;
         int_q  <= int_d;
      end
   end
   assign bus.DAT_O   = dat_q;
   assign bus.ACK_O   = ack_q;
   assign bus.STALL_O = 1'b0;
   assign INTERRUPT_O = int_q;
endmodule
